ram_arbiter: RTL and testbench

- Shares the single-ported RAM between the instruction and data request streams of the pipelined core.
- Sits between the cache-side request interface and the RAM model.
- Grants one requester at a time, holds the grant until the RAM reports completion, and reports completion through per-side wait signals.
- Data has priority; a starvation guard bounds instruction delay. A timeout and error tracker covers hung or faulting RAM accesses.

---
 rtl/ram_arbiter.sv | 132 +++++++++++++
 tb/tb_ram_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Shares one RAM port between the instruction and data streams. Data wins unless instruction has starved; a grant lasts until the RAM reports ACCESS/ERROR.
// Grant is registered (request in cycle N drives the RAM in N+1); the RAM drive and the wait/load responses are combinational.
module ram_arbiter #(
    parameter int MAX_DGRANTS = 4,
    parameter int TIMEOUT     = 64
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic        iwait,
    output logic [31:0] iload,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic        dwait,
    output logic [31:0] dload,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic [1:0]  ramstate,
    output logic        mem_err,
    output logic [31:0] icount,
    output logic [31:0] dcount
);

    typedef enum logic [1:0] {IDLE, IGRANT, DGRANT} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;
    localparam int SW = $clog2(MAX_DGRANTS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state, state_nxt;
    logic [TW-1:0]   tcnt;
    logic [SW-1:0]   starve_cnt;
    logic            ram_done, timed_out, forced;
    logic            i_done, d_done, fault;

    assign ram_done  = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);
    assign timed_out = (tcnt == TW'(TIMEOUT - 1));
    assign forced    = iREN && (starve_cnt == SW'(MAX_DGRANTS));

    always_comb begin
        state_nxt = state;
        ramREN    = 1'b0;
        ramWEN    = 1'b0;
        ramaddr   = '0;
        ramstore  = '0;
        iwait     = 1'b1;
        dwait     = 1'b1;
        iload     = '0;
        dload     = '0;
        i_done    = 1'b0;
        d_done    = 1'b0;
        fault     = 1'b0;
        case (state)
            IDLE: begin
                if ((dREN || dWEN) && !forced)
                    state_nxt = DGRANT;
                else if (iREN)
                    state_nxt = IGRANT;
            end
            IGRANT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iload   = ramload;
                if (!iREN) begin
                    state_nxt = IDLE;
                end else if (ram_done || timed_out) begin
                    // a timeout is reported as a faulted completion so the core never hangs
                    iwait     = 1'b0;
                    i_done    = 1'b1;
                    fault     = (ramstate == RAM_ERROR) || !ram_done;
                    state_nxt = IDLE;
                end
            end
            DGRANT: begin
                ramWEN   = dWEN;
                ramREN   = dREN && !dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dload    = ramload;
                if (!(dREN || dWEN)) begin
                    state_nxt = IDLE;
                end else if (ram_done || timed_out) begin
                    dwait     = 1'b0;
                    d_done    = 1'b1;
                    fault     = (ramstate == RAM_ERROR) || !ram_done;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            tcnt       <= '0;
            starve_cnt <= '0;
            mem_err    <= 1'b0;
            icount     <= '0;
            dcount     <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE || state_nxt == IDLE)
                tcnt <= '0;
            else
                tcnt <= tcnt + TW'(1);
            if (fault)
                mem_err <= 1'b1;
            if (i_done)
                icount <= icount + 32'd1;
            if (d_done)
                dcount <= dcount + 32'd1;
            // starvation only accrues while instruction is actually waiting
            if (i_done)
                starve_cnt <= '0;
            else if (d_done) begin
                if (!iREN)
                    starve_cnt <= '0;
                else if (starve_cnt != SW'(MAX_DGRANTS))
                    starve_cnt <= starve_cnt + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: stimulus pushes expected completions, a negedge monitor pops and compares them.
module tb_ram_arbiter;

    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic        iwait, dwait, ramREN, ramWEN, mem_err;
    logic [31:0] iload, dload, ramaddr, ramstore, icount, dcount;

    typedef struct {
        logic        side;
        logic [31:0] load;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_i = 0;
    int   exp_d = 0;

    ram_arbiter #(.MAX_DGRANTS(4), .TIMEOUT(64)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dwait(dwait), .dload(dload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate),
        .mem_err(mem_err), .icount(icount), .dcount(dcount)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // completion monitor
    always @(negedge CLK) begin
        exp_t e;
        if (nRST === 1'b1 && (iwait === 1'b0 || dwait === 1'b0)) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_completion: iwait=%b dwait=%b expected none at %0t",
                         iwait, dwait, $time);
            end else begin
                e = exp_q.pop_front();
                chk("done_wait",  e.side ? dwait : iwait, 32'd0);
                chk("other_wait", e.side ? iwait : dwait, 32'd1);
                chk("done_load",  e.side ? dload : iload, e.load);
                chk("other_load", e.side ? iload : dload, 32'd0);
            end
        end
    end

    // single request from IDLE: grant, busy cycles, then the final ramstate
    task automatic do_access(input logic is_d, input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdat, input int busy,
                             input logic [1:0] fin, input logic [31:0] rdat);
        if (is_d) begin
            dREN = !wr; dWEN = wr; daddr = addr; dstore = wdat;
        end else begin
            iREN = 1'b1; iaddr = addr;
        end
        ramstate = FREE;
        tick();
        for (int b = 0; b < busy; b++) begin
            ramstate = BUSY;
            @(negedge CLK);
            chk("busy_wait", is_d ? dwait : iwait, 32'd1);
            chk("ram_en", (is_d && wr) ? ramWEN : ramREN, 32'd1);
            chk("ram_addr", ramaddr, addr);
            tick();
        end
        ramstate = fin;
        ramload = rdat;
        exp_q.push_back('{is_d, rdat});
        @(negedge CLK);
        if (is_d && wr) chk("ram_store", ramstore, wdat);
        tick();
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        ramstate = FREE; ramload = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b1;
        iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0;
        ramload = '0; ramstate = FREE;
        #1 nRST = 1'b0;
        #2;
        chk("rst_ramREN", ramREN, 32'd0);
        chk("rst_ramWEN", ramWEN, 32'd0);
        chk("rst_ramaddr", ramaddr, 32'd0);
        chk("rst_ramstore", ramstore, 32'd0);
        chk("rst_iwait", iwait, 32'd1);
        chk("rst_dwait", dwait, 32'd1);
        chk("rst_iload", iload, 32'd0);
        chk("rst_dload", dload, 32'd0);
        chk("rst_mem_err", mem_err, 32'd0);
        chk("rst_icount", icount, 32'd0);
        chk("rst_dcount", dcount, 32'd0);
        #9 nRST = 1'b1;
        tick();

        // single instruction read, two BUSY cycles then ACCESS
        do_access(1'b0, 1'b0, 32'h100, 32'h0, 2, ACCESS, 32'hDEADBEEF);
        exp_i++;
        chk("t1_icount", icount, exp_i);

        // simultaneous instruction read and data write: data first, bubble, then instruction
        iREN = 1'b1; iaddr = 32'h300;
        dWEN = 1'b1; daddr = 32'h200; dstore = 32'h55;
        tick();
        ramstate = ACCESS; ramload = 32'h0;
        exp_q.push_back('{1'b1, 32'h0});
        @(negedge CLK);
        chk("t2_ramWEN", ramWEN, 32'd1);
        chk("t2_ramREN", ramREN, 32'd0);
        chk("t2_ramaddr", ramaddr, 32'h200);
        chk("t2_ramstore", ramstore, 32'h55);
        tick();
        dWEN = 1'b0; ramstate = FREE;
        @(negedge CLK);
        chk("t2_bubble_ramREN", ramREN, 32'd0);
        chk("t2_bubble_iwait", iwait, 32'd1);
        tick();
        ramstate = ACCESS; ramload = 32'h1234;
        exp_q.push_back('{1'b0, 32'h1234});
        @(negedge CLK);
        chk("t2_igrant_ramREN", ramREN, 32'd1);
        chk("t2_igrant_ramaddr", ramaddr, 32'h300);
        tick();
        iREN = 1'b0; ramstate = FREE; ramload = '0;
        exp_d++; exp_i++;
        chk("t2_dcount", dcount, exp_d);
        chk("t2_icount", icount, exp_i);

        // starvation guard: four data grants, forced instruction, then data wins again
        iREN = 1'b1; iaddr = 32'h400;
        dREN = 1'b1; daddr = 32'h500;
        for (int k = 0; k < 6; k++) begin
            logic exp_side;
            exp_side = (k != 4);
            tick();
            ramstate = ACCESS;
            ramload = 32'hA000_0000 + 32'(k);
            exp_q.push_back('{exp_side, ramload});
            @(negedge CLK);
            chk("t3_arb_addr", ramaddr, exp_side ? 32'h500 : 32'h400);
            tick();
            ramstate = FREE; ramload = '0;
            if (exp_side) exp_d++;
            else exp_i++;
        end
        iREN = 1'b0; dREN = 1'b0;
        chk("t3_dcount", dcount, exp_d);
        chk("t3_icount", icount, exp_i);

        // ERROR on an instruction grant
        chk("t5_mem_err_before", mem_err, 32'd0);
        do_access(1'b0, 1'b0, 32'h180, 32'h0, 1, ERROR, 32'hBAD0BAD0);
        exp_i++;
        chk("t5_mem_err", mem_err, 32'd1);
        chk("t5_icount", icount, exp_i);

        // asynchronous reset in the middle of an instruction grant
        iREN = 1'b1; iaddr = 32'h900;
        tick();
        ramstate = BUSY;
        #2;
        chk("t6_pre_ramREN", ramREN, 32'd1);
        nRST = 1'b0;
        #1;
        chk("t6_ramREN", ramREN, 32'd0);
        chk("t6_ramaddr", ramaddr, 32'd0);
        chk("t6_iwait", iwait, 32'd1);
        chk("t6_mem_err", mem_err, 32'd0);
        chk("t6_icount", icount, 32'd0);
        chk("t6_dcount", dcount, 32'd0);
        iREN = 1'b0; ramstate = FREE;
        exp_i = 0; exp_d = 0;
        @(negedge CLK);
        nRST = 1'b1;
        tick();

        // data read with RAM stuck BUSY: completion forced in grant cycle 64
        dREN = 1'b1; daddr = 32'h600; ramstate = BUSY; ramload = 32'h7777_0000;
        tick();
        for (int g = 1; g <= 64; g++) begin
            if (g == 64) exp_q.push_back('{1'b1, 32'h7777_0000});
            @(negedge CLK);
            if (g < 64) chk("t4_dwait_high", dwait, 32'd1);
            tick();
        end
        dREN = 1'b0; ramstate = FREE; ramload = '0;
        exp_d++;
        chk("t4_mem_err", mem_err, 32'd1);
        chk("t4_dcount", dcount, exp_d);
        do_access(1'b1, 1'b0, 32'h640, 32'h0, 1, ACCESS, 32'h1111_2222);
        exp_d++;
        chk("t4_mem_err_sticky", mem_err, 32'd1);
        chk("t4_dcount_after", dcount, exp_d);

        // data request withdrawn while RAM is BUSY
        dREN = 1'b1; daddr = 32'h700; ramstate = FREE;
        tick();
        ramstate = BUSY;
        @(negedge CLK);
        chk("t7_ramREN_granted", ramREN, 32'd1);
        tick();
        dREN = 1'b0;
        #1;
        chk("t7_ramREN_drop", ramREN, 32'd0);
        chk("t7_ramWEN_drop", ramWEN, 32'd0);
        chk("t7_dwait", dwait, 32'd1);
        tick();
        ramstate = FREE;
        @(negedge CLK);
        chk("t7_idle_ramREN", ramREN, 32'd0);
        chk("t7_dcount", dcount, exp_d);
        tick();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
